// File: rtl/deserializer_if.sv
// deserializer_if: serial bit stream in, valid/ready parallel word out.
//   serial_in/serial_valid : bit stream from the serializer (LSB first)
//   data_out/out_valid/out_ready : one-entry output register handshake
//   overrun/clear_overrun  : sticky dropped-word flag and its clear
//   frame_error            : abort pulse, present only with DESER_FRAME_ERR_EN
interface deserializer_if #(parameter int DATA_WIDTH = 8);
  logic serial_in;
  logic serial_valid;
  logic [DATA_WIDTH-1:0] data_out;
  logic out_valid;
  logic out_ready;
  logic overrun;
  logic clear_overrun;
`ifdef DESER_FRAME_ERR_EN
  logic frame_error;
`endif
  modport master (
    output serial_in, serial_valid, out_ready, clear_overrun,
`ifdef DESER_FRAME_ERR_EN
    input frame_error,
`endif
    input data_out, out_valid, overrun
  );
  modport slave (
    input serial_in, serial_valid, out_ready, clear_overrun,
`ifdef DESER_FRAME_ERR_EN
    output frame_error,
`endif
    output data_out, out_valid, overrun
  );
endinterface

// File: rtl/deserializer.sv
// deserializer: reassembles an LSB-first bit stream into words held in a one-entry valid/ready register.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus (slave)  : serial_in/serial_valid in, data_out/out_valid/out_ready out,
//                  overrun/clear_overrun, frame_error when DESER_FRAME_ERR_EN is defined
module deserializer #(
  parameter int DATA_WIDTH = 8
) (
  input logic clock,
  input logic reset,
  deserializer_if.slave bus
);
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction
  localparam int COUNTER_SIZE = clog2(DATA_WIDTH) + 1;
  // The oldest bit leaves the shifter before it is ever read, so only the upper W-1 bits are stored.
  logic [DATA_WIDTH-2:0] shift_reg;
  logic [DATA_WIDTH-1:0] next_word;
  logic [COUNTER_SIZE-1:0] bit_count;
  logic last, complete, pop;
  assign next_word = {bus.serial_in, shift_reg};
  assign last = bit_count == COUNTER_SIZE'(DATA_WIDTH - 1);
  assign complete = bus.serial_valid && last;
  assign pop = bus.out_valid && bus.out_ready;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      bit_count <= '0;
      bus.data_out <= '0;
      bus.out_valid <= 1'b0;
      bus.overrun <= 1'b0;
`ifdef DESER_FRAME_ERR_EN
      bus.frame_error <= 1'b0;
`endif
    end else begin
      shift_reg <= bus.serial_valid ? next_word[DATA_WIDTH-1:1] : shift_reg;
      // A low strobe in mid-frame discards the partial word; in idle it is a no-op either way.
      bit_count <= (bus.serial_valid && !last) ? bit_count + 1'b1 : '0;
      if (complete && (!bus.out_valid || pop)) begin
        bus.data_out <= next_word;
        bus.out_valid <= 1'b1;
      end else if (pop) begin
        bus.out_valid <= 1'b0;
      end
      bus.overrun <= (complete && bus.out_valid && !pop) || (bus.overrun && !bus.clear_overrun);
`ifdef DESER_FRAME_ERR_EN
      bus.frame_error <= !bus.serial_valid && bit_count != '0;
`endif
    end
  end
endmodule
